// File: rtl/axi_aw_splitter.sv
// AXI4 write-address burst splitter.
// Reissues each AW request unchanged, or cuts INCR bursts longer than
// MAX_BEATS into back-to-back sub-bursts of at most MAX_BEATS beats.
// master_last_o marks the final (or only) piece so the B-channel merger
// can collapse the sub-burst responses. The output is fully registered.
module axi_aw_splitter #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int MAX_BEATS  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  slave_valid_i,
    output logic                  slave_ready_o,
    input  logic [ADDR_WIDTH-1:0] slave_addr_i,
    input  logic [2:0]            slave_prot_i,
    input  logic [3:0]            slave_region_i,
    input  logic [7:0]            slave_len_i,
    input  logic [2:0]            slave_size_i,
    input  logic [1:0]            slave_burst_i,
    input  logic                  slave_lock_i,
    input  logic [3:0]            slave_cache_i,
    input  logic [3:0]            slave_qos_i,
    input  logic [ID_WIDTH-1:0]   slave_id_i,
    input  logic [USER_WIDTH-1:0] slave_user_i,
    output logic                  master_valid_o,
    input  logic                  master_ready_i,
    output logic [ADDR_WIDTH-1:0] master_addr_o,
    output logic [2:0]            master_prot_o,
    output logic [3:0]            master_region_o,
    output logic [7:0]            master_len_o,
    output logic [2:0]            master_size_o,
    output logic [1:0]            master_burst_o,
    output logic                  master_lock_o,
    output logic [3:0]            master_cache_o,
    output logic [3:0]            master_qos_o,
    output logic [ID_WIDTH-1:0]   master_id_o,
    output logic [USER_WIDTH-1:0] master_user_o,
    output logic                  master_last_o
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    localparam logic [8:0] MAX_BEATS_W = 9'(MAX_BEATS);
    localparam logic [7:0] MAX_LEN_W   = 8'(MAX_BEATS - 1);

    // Address distance covered by one full-size sub-burst
    function automatic logic [ADDR_WIDTH-1:0] burst_step(input logic [2:0] size);
        return ADDR_WIDTH'(MAX_BEATS) << size;
    endfunction

    // Clear the low 'size' address bits (beat alignment)
    function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                         input logic [2:0] size);
        return addr & ({ADDR_WIDTH{1'b1}} << size);
    endfunction

    state_e                state_r, state_s;
    logic [8:0]            rem_r, rem_s;
    logic [ADDR_WIDTH-1:0] next_addr_r, next_addr_s;

    logic                  valid_s, last_s, lock_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [2:0]            prot_s, size_s;
    logic [3:0]            region_s, cache_s, qos_s;
    logic [7:0]            len_s;
    logic [1:0]            burst_s;
    logic [ID_WIDTH-1:0]   id_s;
    logic [USER_WIDTH-1:0] user_s;

    logic                  accept_s, out_hs_s, need_split_s;
    logic [8:0]            piece_s, beats_in_s;

    assign slave_ready_o = (state_r == IDLE) && (!master_valid_o || master_ready_i);
    assign accept_s      = slave_valid_i && slave_ready_o;
    assign out_hs_s      = master_valid_o && master_ready_i;
    assign beats_in_s    = {1'b0, slave_len_i} + 9'd1;
    assign need_split_s  = (slave_burst_i == 2'b01) && (beats_in_s > MAX_BEATS_W);
    assign piece_s       = (rem_r > MAX_BEATS_W) ? MAX_BEATS_W : rem_r;

    // Next-state and next output-register contents
    always_comb begin
        state_s     = state_r;
        rem_s       = rem_r;
        next_addr_s = next_addr_r;
        valid_s     = master_valid_o;
        last_s      = master_last_o;
        addr_s      = master_addr_o;
        prot_s      = master_prot_o;
        region_s    = master_region_o;
        len_s       = master_len_o;
        size_s      = master_size_o;
        burst_s     = master_burst_o;
        lock_s      = master_lock_o;
        cache_s     = master_cache_o;
        qos_s       = master_qos_o;
        id_s        = master_id_o;
        user_s      = master_user_o;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    valid_s  = 1'b1;
                    addr_s   = slave_addr_i;
                    prot_s   = slave_prot_i;
                    region_s = slave_region_i;
                    size_s   = slave_size_i;
                    burst_s  = slave_burst_i;
                    lock_s   = slave_lock_i;
                    cache_s  = slave_cache_i;
                    qos_s    = slave_qos_i;
                    id_s     = slave_id_i;
                    user_s   = slave_user_i;
                    if (need_split_s) begin
                        len_s       = MAX_LEN_W;
                        last_s      = 1'b0;
                        rem_s       = beats_in_s - MAX_BEATS_W;
                        next_addr_s = align_addr(slave_addr_i, slave_size_i)
                                      + burst_step(slave_size_i);
                        state_s     = SPLIT;
                    end else begin
                        len_s   = slave_len_i;
                        last_s  = 1'b1;
                        rem_s   = 9'd0;
                        state_s = IDLE;
                    end
                end else if (out_hs_s) begin
                    valid_s = 1'b0;
                end else begin
                    valid_s = master_valid_o;
                end
            end
            SPLIT: begin
                if (out_hs_s) begin
                    valid_s     = 1'b1;
                    addr_s      = next_addr_r;
                    len_s       = 8'(piece_s - 9'd1);
                    next_addr_s = next_addr_r + burst_step(master_size_o);
                    rem_s       = rem_r - piece_s;
                    if (rem_r <= MAX_BEATS_W) begin
                        last_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        last_s  = 1'b0;
                        state_s = SPLIT;
                    end
                end else begin
                    state_s = SPLIT;
                end
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
            end
        endcase
    end

    // State, bookkeeping and output register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r         <= IDLE;
            rem_r           <= 9'd0;
            next_addr_r     <= '0;
            master_valid_o  <= 1'b0;
            master_last_o   <= 1'b0;
            master_addr_o   <= '0;
            master_prot_o   <= 3'd0;
            master_region_o <= 4'd0;
            master_len_o    <= 8'd0;
            master_size_o   <= 3'd0;
            master_burst_o  <= 2'd0;
            master_lock_o   <= 1'b0;
            master_cache_o  <= 4'd0;
            master_qos_o    <= 4'd0;
            master_id_o     <= '0;
            master_user_o   <= '0;
        end else begin
            state_r         <= state_s;
            rem_r           <= rem_s;
            next_addr_r     <= next_addr_s;
            master_valid_o  <= valid_s;
            master_last_o   <= last_s;
            master_addr_o   <= addr_s;
            master_prot_o   <= prot_s;
            master_region_o <= region_s;
            master_len_o    <= len_s;
            master_size_o   <= size_s;
            master_burst_o  <= burst_s;
            master_lock_o   <= lock_s;
            master_cache_o  <= cache_s;
            master_qos_o    <= qos_s;
            master_id_o     <= id_s;
            master_user_o   <= user_s;
        end
    end

endmodule

// File: tb/tb_axi_aw_splitter.sv
// Directed self-checking bench for axi_aw_splitter (MAX_BEATS=16, 32-bit addresses).
module tb_axi_aw_splitter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        slave_valid_i, slave_ready_o;
    logic [31:0] slave_addr_i;
    logic [2:0]  slave_prot_i, slave_size_i;
    logic [3:0]  slave_region_i, slave_cache_i, slave_qos_i;
    logic [7:0]  slave_len_i;
    logic [1:0]  slave_burst_i;
    logic        slave_lock_i;
    logic [3:0]  slave_id_i;
    logic [1:0]  slave_user_i;
    logic        master_valid_o, master_ready_i;
    logic [31:0] master_addr_o;
    logic [2:0]  master_prot_o, master_size_o;
    logic [3:0]  master_region_o, master_cache_o, master_qos_o;
    logic [7:0]  master_len_o;
    logic [1:0]  master_burst_o;
    logic        master_lock_o;
    logic [3:0]  master_id_o;
    logic [1:0]  master_user_o;
    logic        master_last_o;

    int n_cmp = 0;
    int n_fail = 0;

    // valid, addr, len, last
    wire [41:0] obs = {master_valid_o, master_addr_o, master_len_o, master_last_o};
    // prot, region, size, burst, lock, cache, qos, id, user
    wire [26:0] side = {master_prot_o, master_region_o, master_size_o, master_burst_o,
                        master_lock_o, master_cache_o, master_qos_o, master_id_o, master_user_o};

    axi_aw_splitter #(.ID_WIDTH(4), .ADDR_WIDTH(32), .USER_WIDTH(2), .MAX_BEATS(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .slave_valid_i(slave_valid_i), .slave_ready_o(slave_ready_o),
        .slave_addr_i(slave_addr_i), .slave_prot_i(slave_prot_i), .slave_region_i(slave_region_i),
        .slave_len_i(slave_len_i), .slave_size_i(slave_size_i), .slave_burst_i(slave_burst_i),
        .slave_lock_i(slave_lock_i), .slave_cache_i(slave_cache_i), .slave_qos_i(slave_qos_i),
        .slave_id_i(slave_id_i), .slave_user_i(slave_user_i),
        .master_valid_o(master_valid_o), .master_ready_i(master_ready_i),
        .master_addr_o(master_addr_o), .master_prot_o(master_prot_o),
        .master_region_o(master_region_o), .master_len_o(master_len_o),
        .master_size_o(master_size_o), .master_burst_o(master_burst_o),
        .master_lock_o(master_lock_o), .master_cache_o(master_cache_o),
        .master_qos_o(master_qos_o), .master_id_o(master_id_o), .master_user_o(master_user_o),
        .master_last_o(master_last_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id);
        slave_valid_i  = 1'b1;
        slave_addr_i   = addr;
        slave_len_i    = len;
        slave_size_i   = size;
        slave_burst_i  = burst;
        slave_id_i     = id;
        slave_prot_i   = 3'd2;
        slave_region_i = 4'd1;
        slave_lock_i   = 1'b1;
        slave_cache_i  = 4'd3;
        slave_qos_i    = 4'd5;
        slave_user_i   = 2'd1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        slave_valid_i = 1'b0;
        master_ready_i = 1'b1;
        set_req(32'h0, 8'd0, 3'd0, 2'b01, 4'd0);
        slave_valid_i = 1'b0;
        step();
        step();
        n_cmp++;
        if ({obs, side} !== 69'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {obs, side});
        end
        n_cmp++;
        if (slave_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1", slave_ready_o);
        end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_passthrough();
        set_req(32'h1000, 8'd7, 3'd2, 2'b01, 4'd3);
        n_cmp++;
        if (slave_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_ready: got %b required 1", slave_ready_o);
        end
        step();
        slave_valid_i = 1'b0;
        n_cmp++;
        if (obs !== {1'b1, 32'h1000, 8'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL pass_out: got %h required %h", obs, {1'b1, 32'h1000, 8'd7, 1'b1});
        end
        n_cmp++;
        if (side !== {3'd2, 4'd1, 3'd2, 2'b01, 1'b1, 4'd3, 4'd5, 4'd3, 2'd1}) begin
            n_fail++;
            $display("FAIL pass_fields: got %h required %h", side,
                     {3'd2, 4'd1, 3'd2, 2'b01, 1'b1, 4'd3, 4'd5, 4'd3, 2'd1});
        end
        step();
        n_cmp++;
        if (master_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_valid_drop: got %b required 0", master_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        set_req(32'h0, 8'd0, 3'd2, 2'b01, 4'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if ({obs, master_id_o} !== {1'b1, 32'(i) * 32'h100, 8'(i), 1'b1, 4'(i)}) begin
                n_fail++;
                $display("FAIL b2b_%0d: got %h required %h", i, {obs, master_id_o},
                         {1'b1, 32'(i) * 32'h100, 8'(i), 1'b1, 4'(i)});
            end
            if (i < 3) set_req(32'(i + 1) * 32'h100, 8'(i + 1), 3'd2, 2'b01, 4'(i + 1));
            else slave_valid_i = 1'b0;
        end
        step();
        n_cmp++;
        if (master_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drop: got %b required 0", master_valid_o);
        end
    endtask

    task automatic test_split();
        set_req(32'h1006, 8'd39, 3'd2, 2'b01, 4'd5);
        step();
        slave_valid_i = 1'b0;
        n_cmp++;
        if ({obs, slave_ready_o} !== {1'b1, 32'h1006, 8'd15, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL split_p1: got %h required %h", {obs, slave_ready_o},
                     {1'b1, 32'h1006, 8'd15, 1'b0, 1'b0});
        end
        step();
        n_cmp++;
        if ({obs, slave_ready_o, master_id_o} !== {1'b1, 32'h1044, 8'd15, 1'b0, 1'b0, 4'd5}) begin
            n_fail++;
            $display("FAIL split_p2: got %h required %h", {obs, slave_ready_o, master_id_o},
                     {1'b1, 32'h1044, 8'd15, 1'b0, 1'b0, 4'd5});
        end
        step();
        n_cmp++;
        if ({obs, slave_ready_o, side} !==
            {1'b1, 32'h1084, 8'd7, 1'b1, 1'b1, 3'd2, 4'd1, 3'd2, 2'b01, 1'b1, 4'd3, 4'd5, 4'd5, 2'd1}) begin
            n_fail++;
            $display("FAIL split_p3: got %h required %h", {obs, slave_ready_o, side},
                     {1'b1, 32'h1084, 8'd7, 1'b1, 1'b1, 3'd2, 4'd1, 3'd2, 2'b01, 1'b1, 4'd3, 4'd5, 4'd5, 2'd1});
        end
        step();
        n_cmp++;
        if (master_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL split_drop: got %b required 0", master_valid_o);
        end
    endtask

    task automatic test_exact_multiple();
        set_req(32'h2000, 8'd31, 3'd3, 2'b01, 4'd1);
        step();
        slave_valid_i = 1'b0;
        n_cmp++;
        if (obs !== {1'b1, 32'h2000, 8'd15, 1'b0}) begin
            n_fail++;
            $display("FAIL exact_p1: got %h required %h", obs, {1'b1, 32'h2000, 8'd15, 1'b0});
        end
        step();
        n_cmp++;
        if ({obs, slave_ready_o} !== {1'b1, 32'h2080, 8'd15, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL exact_p2: got %h required %h", {obs, slave_ready_o},
                     {1'b1, 32'h2080, 8'd15, 1'b1, 1'b1});
        end
        // accepted in the same edge that retires the last piece
        set_req(32'h3000, 8'd15, 3'd3, 2'b01, 4'd2);
        step();
        slave_valid_i = 1'b0;
        n_cmp++;
        if (obs !== {1'b1, 32'h3000, 8'd15, 1'b1}) begin
            n_fail++;
            $display("FAIL exact_len15: got %h required %h", obs, {1'b1, 32'h3000, 8'd15, 1'b1});
        end
        step();
    endtask

    task automatic test_non_incr();
        set_req(32'h4000, 8'd15, 3'd2, 2'b10, 4'd1);
        step();
        set_req(32'h5000, 8'd255, 3'd2, 2'b00, 4'd2);
        n_cmp++;
        if ({obs, master_burst_o} !== {1'b1, 32'h4000, 8'd15, 1'b1, 2'b10}) begin
            n_fail++;
            $display("FAIL wrap_pass: got %h required %h", {obs, master_burst_o},
                     {1'b1, 32'h4000, 8'd15, 1'b1, 2'b10});
        end
        step();
        set_req(32'h5100, 8'd31, 3'd2, 2'b11, 4'd3);
        n_cmp++;
        if ({obs, master_burst_o} !== {1'b1, 32'h5000, 8'd255, 1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL fixed_pass: got %h required %h", {obs, master_burst_o},
                     {1'b1, 32'h5000, 8'd255, 1'b1, 2'b00});
        end
        step();
        slave_valid_i = 1'b0;
        n_cmp++;
        if ({obs, master_burst_o} !== {1'b1, 32'h5100, 8'd31, 1'b1, 2'b11}) begin
            n_fail++;
            $display("FAIL rsvd_pass: got %h required %h", {obs, master_burst_o},
                     {1'b1, 32'h5100, 8'd31, 1'b1, 2'b11});
        end
        step();
    endtask

    task automatic test_backpressure();
        set_req(32'h1006, 8'd39, 3'd2, 2'b01, 4'd7);
        step();
        slave_valid_i = 1'b0;
        master_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({obs, side, slave_ready_o} !==
                {1'b1, 32'h1006, 8'd15, 1'b0, 3'd2, 4'd1, 3'd2, 2'b01, 1'b1, 4'd3, 4'd5, 4'd7, 2'd1, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_%0d: got %h required %h", i, {obs, side, slave_ready_o},
                         {1'b1, 32'h1006, 8'd15, 1'b0, 3'd2, 4'd1, 3'd2, 2'b01, 1'b1, 4'd3, 4'd5, 4'd7, 2'd1, 1'b0});
            end
            step();
        end
        master_ready_i = 1'b1;
        step();
        n_cmp++;
        if (obs !== {1'b1, 32'h1044, 8'd15, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_p2: got %h required %h", obs, {1'b1, 32'h1044, 8'd15, 1'b0});
        end
        step();
        n_cmp++;
        if (obs !== {1'b1, 32'h1084, 8'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_p3: got %h required %h", obs, {1'b1, 32'h1084, 8'd7, 1'b1});
        end
        step();
    endtask

    task automatic test_addr_wrap();
        set_req(32'hFFFF_FFC0, 8'd31, 3'd2, 2'b01, 4'd4);
        step();
        slave_valid_i = 1'b0;
        n_cmp++;
        if (obs !== {1'b1, 32'hFFFF_FFC0, 8'd15, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_p1: got %h required %h", obs, {1'b1, 32'hFFFF_FFC0, 8'd15, 1'b0});
        end
        step();
        n_cmp++;
        if (obs !== {1'b1, 32'h0000_0000, 8'd15, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_p2: got %h required %h", obs, {1'b1, 32'h0000_0000, 8'd15, 1'b1});
        end
        step();
    endtask

    task automatic test_reset_mid_split();
        set_req(32'h1000, 8'd47, 3'd2, 2'b01, 4'd6);
        step();
        slave_valid_i = 1'b0;
        step();
        n_cmp++;
        if (obs !== {1'b1, 32'h1040, 8'd15, 1'b0}) begin
            n_fail++;
            $display("FAIL rmid_p2: got %h required %h", obs, {1'b1, 32'h1040, 8'd15, 1'b0});
        end
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({master_valid_o, slave_ready_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL rmid_async: got %b required 01", {master_valid_o, slave_ready_o});
        end
        step();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({master_valid_o, slave_ready_o} !== 2'b01) begin
                n_fail++;
                $display("FAIL rmid_stale_%0d: got %b required 01", i, {master_valid_o, slave_ready_o});
            end
        end
        set_req(32'h6000, 8'd3, 3'd2, 2'b01, 4'd9);
        step();
        slave_valid_i = 1'b0;
        n_cmp++;
        if ({obs, master_id_o} !== {1'b1, 32'h6000, 8'd3, 1'b1, 4'd9}) begin
            n_fail++;
            $display("FAIL rmid_new: got %h required %h", {obs, master_id_o},
                     {1'b1, 32'h6000, 8'd3, 1'b1, 4'd9});
        end
        step();
        n_cmp++;
        if (master_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_drop: got %b required 0", master_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_back_to_back();
        test_split();
        test_exact_multiple();
        test_non_incr();
        test_backpressure();
        test_addr_wrap();
        test_reset_mid_split();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
